// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//
// Two-port memory arbiter. An instruction-fetch port and a load/store data
// port share a single word-wide memory with a req/ack handshake of variable
// latency. Data normally wins over fetch; a starvation counter bounds how
// many consecutive data grants may be issued while fetch is waiting.
//
// Each access walks IDLE -> F_BUSY/D_BUSY -> DONE -> IDLE. DONE carries the
// one-cycle ready pulse back to the requester and blocks a new grant, giving
// the requester a cycle to drop its request.
//
// Ports
//   clk              sole clock, all state updates on posedge
//   reset            asynchronous, active-high reset
//   halt             blocks new grants while in IDLE (in-flight access completes)
//   f_req/f_addr     fetch request and word address (held until f_ready)
//   f_ready/f_data   one-cycle fetch completion pulse and fetched word
//   d_req/d_we       data request, 1 = store / 0 = load (held until d_ready)
//   d_addr/d_wdata   data word address and store data
//   d_ready/d_rdata  one-cycle data completion pulse and load result
//   m_req/m_we       memory request (held until m_ack) and write enable
//   m_addr/m_wdata   memory address and write data, stable while m_req is high
//   m_ack/m_rdata    memory completion and read data (valid with m_ack)
//   idle             high exactly while the arbiter is in IDLE
//
// Parameter
//   STARVE_LIMIT     consecutive data grants allowed while fetch waits (1..15)
// -----------------------------------------------------------------------------
module mem_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    // fetch port
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ready,
    output logic [15:0] f_data,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    // memory port
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic        m_ack,
    input  logic [15:0] m_rdata,
    // status
    output logic        idle
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  starve_cnt_r;

    logic        fetch_priority_s;
    logic        grant_data_s;
    logic        grant_fetch_s;
    logic [3:0]  starve_next_s;

    // Arbitration decision for the IDLE state: data first unless fetch has
    // waited through STARVE_LIMIT consecutive data grants.
    always_comb begin
        fetch_priority_s = 1'b0;
        grant_data_s     = 1'b0;
        grant_fetch_s    = 1'b0;
        if (f_req && (starve_cnt_r == LIMIT_C)) begin
            fetch_priority_s = 1'b1;
        end else begin
            fetch_priority_s = 1'b0;
        end
        if (d_req && !fetch_priority_s) begin
            grant_data_s = 1'b1;
        end else if (f_req) begin
            grant_fetch_s = 1'b1;
        end else begin
            grant_data_s  = 1'b0;
            grant_fetch_s = 1'b0;
        end
    end

    // Starvation count after a data grant: counts up (saturating) only while
    // fetch is being passed over; a data grant with no fetch pending restarts.
    always_comb begin
        starve_next_s = 4'd0;
        if (f_req) begin
            if (starve_cnt_r < LIMIT_C) begin
                starve_next_s = starve_cnt_r + 4'd1;
            end else begin
                starve_next_s = starve_cnt_r;
            end
        end else begin
            starve_next_s = 4'd0;
        end
    end

    // Access FSM with all outputs registered; reset abandons any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= 16'h0000;
            m_wdata      <= 16'h0000;
            f_ready      <= 1'b0;
            d_ready      <= 1'b0;
            f_data       <= 16'h0000;
            d_rdata      <= 16'h0000;
            idle         <= 1'b1;
        end else begin
            // Ready pulses last a single cycle unless re-asserted below.
            f_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!halt && grant_data_s) begin
                        m_req        <= 1'b1;
                        m_we         <= d_we;
                        m_addr       <= d_addr;
                        m_wdata      <= d_wdata;
                        starve_cnt_r <= starve_next_s;
                        idle         <= 1'b0;
                        state_r      <= D_BUSY;
                    end else if (!halt && grant_fetch_s) begin
                        // m_wdata is left as-is: it is meaningless on a read.
                        m_req        <= 1'b1;
                        m_we         <= 1'b0;
                        m_addr       <= f_addr;
                        starve_cnt_r <= 4'd0;
                        idle         <= 1'b0;
                        state_r      <= F_BUSY;
                    end else begin
                        idle    <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                F_BUSY: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        f_data  <= m_rdata;
                        f_ready <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= F_BUSY;
                    end
                end
                D_BUSY: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        // A store completes without disturbing the last load result.
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                        state_r <= DONE;
                    end else begin
                        state_r <= D_BUSY;
                    end
                end
                DONE: begin
                    // No grant here: the requester needs this cycle to drop req.
                    idle    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    m_req   <= 1'b0;
                    idle    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
